// File: rtl/wb_arbiter_if.sv
// Writeback bundle: source result handshakes, issue/operand scoreboard queries, register-file write port.
// Latency: none, signal container only.
// Backpressure: src_ready is the only flow control; the register-file write port has none.
// Ports: src_valid/src_rd/src_wd/src_ready (per-source results), issue_valid/issue_rd/issue_hazard,
//        ra1/ra2/busy1/busy2/fwd1/fwd2 (operand checks), we3/wa3/wd3 (register-file write).
// master = execute/decode side, slave = wb_arbiter.
interface wb_arbiter_if #(
    parameter int N_SRC = 3
);
    logic [N_SRC-1:0]    src_valid;
    logic [5*N_SRC-1:0]  src_rd;
    logic [32*N_SRC-1:0] src_wd;
    logic [N_SRC-1:0]    src_ready;
    logic                issue_valid;
    logic [4:0]          issue_rd;
    logic                issue_hazard;
    logic [4:0]          ra1;
    logic [4:0]          ra2;
    logic                busy1;
    logic                busy2;
    logic                we3;
    logic [4:0]          wa3;
    logic [31:0]         wd3;
    logic [31:0]         fwd1;
    logic [31:0]         fwd2;

    modport master (
        output src_valid, src_rd, src_wd, issue_valid, issue_rd, ra1, ra2,
        input  src_ready, issue_hazard, busy1, busy2, we3, wa3, wd3, fwd1, fwd2
    );

    modport slave (
        input  src_valid, src_rd, src_wd, issue_valid, issue_rd, ra1, ra2,
        output src_ready, issue_hazard, busy1, busy2, we3, wa3, wd3, fwd1, fwd2
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter driving the register-file write port, with a pending-write scoreboard.
// Latency: accepted result appears on we3/wa3/wd3 one cycle later; scoreboard clears at the end of that cycle.
// Backpressure: one source granted per cycle (src_ready one-hot or zero); nothing stalls the write port.
// Ports: clk, rst (synchronous, active-high), bus (wb_arbiter_if.slave).
// Optional macro WB_BYPASS_EN: forwards wd3 on fwd1/fwd2 and masks busy1/busy2 for the register being written.
module wb_arbiter #(
    parameter int N_SRC = 3
) (
    input logic          clk,
    input logic          rst,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(N_SRC);

    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  grant_idx;
    logic [PW-1:0]  cand;
    logic [PW:0]    sum;
    logic           grant_vld;
    logic           xfer;
    logic [N_SRC-1:0] ready;
    logic [4:0]     grant_rd;
    logic [31:0]    grant_wd;

    logic [31:0]    pending;
    logic [31:0]    pending_nxt;
    logic           we3_q;
    logic [4:0]     wa3_q;
    logic [31:0]    wd3_q;

    // First valid source scanning upward from rr_ptr, wrapping at N_SRC.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_SRC)) begin
                sum = sum - (PW+1)'(N_SRC);
            end
            cand = sum[PW-1:0];
            if (!grant_vld && bus.src_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Nothing is accepted while reset is held, so an in-flight handshake is dropped.
    assign xfer = grant_vld && !rst;

    always_comb begin
        ready = '0;
        if (xfer) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign bus.src_ready = ready;
    assign grant_rd      = bus.src_rd[5*grant_idx +: 5];
    assign grant_wd      = bus.src_wd[32*grant_idx +: 32];

    // Clear from the write in flight first, then set from issue, so a same-cycle set wins.
    always_comb begin
        pending_nxt = pending;
        if (we3_q) begin
            pending_nxt[wa3_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            pending_nxt[bus.issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            pending <= '0;
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
        end else begin
            pending <= pending_nxt;
            if (xfer) begin
                rr_ptr <= (grant_idx == PW'(N_SRC-1)) ? '0 : grant_idx + 1'b1;
                // x0 results are consumed but never written.
                we3_q  <= (grant_rd != 5'd0);
                wa3_q  <= grant_rd;
                wd3_q  <= grant_wd;
            end else begin
                we3_q  <= 1'b0;
            end
        end
    end

    assign bus.we3          = we3_q;
    assign bus.wa3          = wa3_q;
    assign bus.wd3          = wd3_q;
    assign bus.issue_hazard = pending[bus.issue_rd];

`ifdef WB_BYPASS_EN
    logic hit1;
    logic hit2;

    // The write on the port this cycle satisfies the operand, so decode takes it from fwdN.
    assign hit1      = we3_q && (wa3_q == bus.ra1) && (bus.ra1 != 5'd0);
    assign hit2      = we3_q && (wa3_q == bus.ra2) && (bus.ra2 != 5'd0);
    assign bus.busy1 = pending[bus.ra1] && !hit1;
    assign bus.busy2 = pending[bus.ra2] && !hit2;
    assign bus.fwd1  = hit1 ? wd3_q : 32'd0;
    assign bus.fwd2  = hit2 ? wd3_q : 32'd0;
`else
    // pending[0] is always 0, so x0 operands never read as busy.
    assign bus.busy1 = pending[bus.ra1];
    assign bus.busy2 = pending[bus.ra2];
    assign bus.fwd1  = 32'd0;
    assign bus.fwd2  = 32'd0;
`endif
endmodule
